// File: rtl/lsb_mem_ctrl.sv
// Byte-serial memory controller between the load/store buffer and a byte-wide RAM.
// Loads and stores of 1, 2 or 4 bytes are sequenced one byte per cycle.
module lsb_mem_ctrl (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        rob_clear_up,
   input  logic        lsb_visit_mem,
   input  logic [6:0]  op_type_in,
   input  logic [2:0]  op_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_val_in,
   output logic        cache_welcome_signal,
   output logic        cache_ready,
   output logic        is_load,
   output logic [31:0] load_val_out,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   localparam logic [6:0] STORE_OPCODE = 7'b0100011;

   typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

   state_t      state;
   logic [2:0]  byte_idx;
   logic [2:0]  byte_cnt;
   logic [31:0] base_addr;
   logic [31:0] data_buf;
   logic        unsigned_ld;
   logic        io_access;
   logic        mem_wr_q;

   logic        accept;
   logic        req_store;
   logic        req_io;
   logic [2:0]  req_cnt;
   logic [2:0]  cap_idx;
   logic [31:0] load_raw;
   logic [31:0] load_ext;

   assign cache_welcome_signal = (state == IDLE) && !rob_clear_up;
   assign accept               = rdy_in && lsb_visit_mem && cache_welcome_signal;
   assign req_store            = (op_type_in == STORE_OPCODE);
   assign req_io               = (addr_in[17:16] == 2'b11);
   assign mem_wr               = mem_wr_q && rdy_in;

   // Load byte k arrives on mem_din two edges after its address was issued.
   assign cap_idx = byte_idx - 3'd2;

   always_comb begin
      case (op_in[1:0])
         2'b00:   req_cnt = 3'd1;
         2'b01:   req_cnt = 3'd2;
         default: req_cnt = 3'd4;
      endcase
   end

   // The final byte is taken straight from mem_din so completion needs no extra cycle.
   always_comb begin
      case (byte_cnt)
         3'd1:    load_raw = {24'd0, mem_din};
         3'd2:    load_raw = {16'd0, mem_din, data_buf[7:0]};
         default: load_raw = {mem_din, data_buf[23:0]};
      endcase
      case (byte_cnt)
         3'd1:    load_ext = unsigned_ld ? {24'd0, load_raw[7:0]}
                                         : {{24{load_raw[7]}}, load_raw[7:0]};
         3'd2:    load_ext = unsigned_ld ? {16'd0, load_raw[15:0]}
                                         : {{16{load_raw[15]}}, load_raw[15:0]};
         default: load_ext = load_raw;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state        <= IDLE;
         byte_idx     <= 3'd0;
         byte_cnt     <= 3'd0;
         base_addr    <= 32'd0;
         data_buf     <= 32'd0;
         unsigned_ld  <= 1'b0;
         io_access    <= 1'b0;
         mem_wr_q     <= 1'b0;
         cache_ready  <= 1'b0;
         is_load      <= 1'b0;
         load_val_out <= 32'd0;
         mem_a        <= 32'd0;
         mem_dout     <= 8'd0;
      end else if (rdy_in) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  base_addr   <= addr_in;
                  byte_cnt    <= req_cnt;
                  unsigned_ld <= op_in[2];
                  io_access   <= req_io;
                  if (req_store) begin
                     state    <= STORE;
                     data_buf <= store_val_in;
                     if (req_io && io_buffer_full) begin
                        mem_wr_q <= 1'b0;
                        byte_idx <= 3'd0;
                     end else begin
                        mem_a    <= addr_in;
                        mem_dout <= store_val_in[7:0];
                        mem_wr_q <= 1'b1;
                        byte_idx <= 3'd1;
                     end
                  end else begin
                     state    <= LOAD;
                     data_buf <= 32'd0;
                     mem_a    <= addr_in;
                     mem_wr_q <= 1'b0;
                     byte_idx <= 3'd1;
                  end
               end
            end

            // byte_idx counts edges since acceptance: issue addresses, then collect bytes.
            LOAD: begin
               if (byte_idx < byte_cnt) begin
                  mem_a <= base_addr + {29'd0, byte_idx};
               end
               if (byte_idx >= 3'd2) begin
                  data_buf[{cap_idx[1:0], 3'b000} +: 8] <= mem_din;
               end
               if (byte_idx == byte_cnt + 3'd1) begin
                  state        <= DONE;
                  cache_ready  <= 1'b1;
                  is_load      <= 1'b1;
                  load_val_out <= load_ext;
                  byte_idx     <= 3'd0;
               end else begin
                  byte_idx <= byte_idx + 3'd1;
               end
            end

            // byte_idx is the next byte to drive; a full UART buffer holds it in place.
            STORE: begin
               if (byte_idx == byte_cnt) begin
                  state        <= DONE;
                  mem_wr_q     <= 1'b0;
                  cache_ready  <= 1'b1;
                  is_load      <= 1'b0;
                  load_val_out <= 32'd0;
                  byte_idx     <= 3'd0;
               end else if (io_access && io_buffer_full) begin
                  mem_wr_q <= 1'b0;
               end else begin
                  mem_a    <= base_addr + {29'd0, byte_idx};
                  mem_dout <= data_buf[{byte_idx[1:0], 3'b000} +: 8];
                  mem_wr_q <= 1'b1;
                  byte_idx <= byte_idx + 3'd1;
               end
            end

            DONE: begin
               state       <= IDLE;
               cache_ready <= 1'b0;
               is_load     <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Directed bench for lsb_mem_ctrl with a byte RAM model and a completion scoreboard.
module tb_lsb_mem_ctrl;

   logic        clk_in;
   logic        rst_in;
   logic        rdy_in;
   logic        rob_clear_up;
   logic        lsb_visit_mem;
   logic [6:0]  op_type_in;
   logic [2:0]  op_in;
   logic [31:0] addr_in;
   logic [31:0] store_val_in;
   logic        cache_welcome_signal;
   logic        cache_ready;
   logic        is_load;
   logic [31:0] load_val_out;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   typedef struct {
      logic        is_ld;
      logic [31:0] val;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] trace_a[$];
   logic        trace_wr[$];
   logic [39:0] write_log[$];
   logic [7:0]  ram [0:65535];
   logic        pre_we;
   logic [15:0] pre_addr;
   logic [7:0]  pre_data;
   int          check_count;
   int          error_count;
   int          pulse_count;
   int          wr_start;
   int          snap;

   lsb_mem_ctrl dut (
      .clk_in               (clk_in),
      .rst_in               (rst_in),
      .rdy_in               (rdy_in),
      .rob_clear_up         (rob_clear_up),
      .lsb_visit_mem        (lsb_visit_mem),
      .op_type_in           (op_type_in),
      .op_in                (op_in),
      .addr_in              (addr_in),
      .store_val_in         (store_val_in),
      .cache_welcome_signal (cache_welcome_signal),
      .cache_ready          (cache_ready),
      .is_load              (is_load),
      .load_val_out         (load_val_out),
      .mem_din              (mem_din),
      .mem_dout             (mem_dout),
      .mem_a                (mem_a),
      .mem_wr               (mem_wr),
      .io_buffer_full       (io_buffer_full)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // RAM: read data follows the address by one cycle; writes land at the edge.
   always @(posedge clk_in) begin
      if (pre_we) begin
         ram[pre_addr] <= pre_data;
      end else if (mem_wr) begin
         ram[mem_a[15:0]] <= mem_dout;
         write_log.push_back({mem_a, mem_dout});
      end
      mem_din <= ram[mem_a[15:0]];
   end

   always @(negedge clk_in) begin
      if (cache_ready) pulse_count <= pulse_count + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      assert (obs === exp) else begin
         error_count++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pokeByte(input logic [15:0] a, input logic [7:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      pre_we   = 1'b0;
   endtask

   task automatic expectDone(input logic ld, input logic [31:0] val, input int lat);
      exp_t e;
      e.is_ld = ld;
      e.val   = val;
      e.lat   = lat;
      sb_q.push_back(e);
   endtask

   task automatic checkWrite(input string tag, input int idx, input logic [31:0] a, input logic [7:0] d);
      logic [39:0] w;
      w = 40'hFF_FFFF_FFFF;
      if (wr_start + idx < write_log.size()) w = write_log[wr_start + idx];
      checkOutput({tag, "_addr"}, w[39:8], a);
      checkOutput({tag, "_data"}, {24'd0, w[7:0]}, {24'd0, d});
   endtask

   // Drives one request from a negedge and follows it to its completion pulse.
   task automatic applyStimulus(input string tag, input logic store, input logic [2:0] op,
                                input logic [31:0] addr, input logic [31:0] sval,
                                input int io_full_edges, input int freeze_at,
                                input int freeze_len, input int flush_at);
      int   k;
      exp_t e;
      trace_a.delete();
      trace_wr.delete();
      wr_start = write_log.size();
      checkOutput({tag, "_welcome"}, {31'd0, cache_welcome_signal}, 32'd1);
      op_type_in     = store ? 7'b0100011 : 7'b0000011;
      op_in          = op;
      addr_in        = addr;
      store_val_in   = sval;
      lsb_visit_mem  = 1'b1;
      io_buffer_full = (io_full_edges > 0);
      @(posedge clk_in);
      k = 0;
      while (1) begin
         @(negedge clk_in);
         trace_a.push_back(mem_a);
         trace_wr.push_back(mem_wr);
         if (cache_ready || k >= 60) break;
         if (k == io_full_edges - 1) io_buffer_full = 1'b0;
         if (k == freeze_at) rdy_in = 1'b0;
         if (k == freeze_at + freeze_len) rdy_in = 1'b1;
         rob_clear_up = (k == flush_at);
         @(posedge clk_in);
         k++;
      end
      lsb_visit_mem  = 1'b0;
      rob_clear_up   = 1'b0;
      io_buffer_full = 1'b0;
      rdy_in         = 1'b1;
      checkOutput({tag, "_ready"}, {31'd0, cache_ready}, 32'd1);
      if (cache_ready) begin
         checkOutput({tag, "_sb_nonempty"}, {31'd0, sb_q.size() != 0}, 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput({tag, "_is_load"}, {31'd0, is_load}, {31'd0, e.is_ld});
            checkOutput({tag, "_value"}, load_val_out, e.val);
            checkOutput({tag, "_latency"}, k, e.lat);
         end
      end
      @(posedge clk_in);
      @(negedge clk_in);
      checkOutput({tag, "_pulse_end"}, {31'd0, cache_ready}, 32'd0);
      checkOutput({tag, "_idle_welcome"}, {31'd0, cache_welcome_signal}, 32'd1);
   endtask

   initial begin
      check_count    = 0;
      error_count    = 0;
      pulse_count    = 0;
      wr_start       = 0;
      pre_we         = 1'b0;
      pre_addr       = 16'd0;
      pre_data       = 8'd0;
      rst_in         = 1'b0;
      rdy_in         = 1'b1;
      rob_clear_up   = 1'b0;
      lsb_visit_mem  = 1'b0;
      op_type_in     = 7'd0;
      op_in          = 3'd0;
      addr_in        = 32'd0;
      store_val_in   = 32'd0;
      io_buffer_full = 1'b0;

      repeat (2) @(negedge clk_in);
      checkOutput("reset_cache_ready", {31'd0, cache_ready}, 32'd0);
      checkOutput("reset_is_load", {31'd0, is_load}, 32'd0);
      checkOutput("reset_load_val", load_val_out, 32'd0);
      checkOutput("reset_mem_a", mem_a, 32'd0);
      checkOutput("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
      checkOutput("reset_mem_dout", {24'd0, mem_dout}, 32'd0);
      rst_in = 1'b1;
      #1;
      checkOutput("welcome_after_reset", {31'd0, cache_welcome_signal}, 32'd1);
      @(negedge clk_in);

      pokeByte(16'h0100, 8'h78);
      pokeByte(16'h0101, 8'h56);
      pokeByte(16'h0102, 8'h34);
      pokeByte(16'h0103, 8'h12);
      pokeByte(16'h0104, 8'h9A);
      pokeByte(16'h0020, 8'h80);
      pokeByte(16'h0040, 8'h01);
      pokeByte(16'h0041, 8'h80);
      pokeByte(16'hFFFE, 8'hAA);
      pokeByte(16'hFFFF, 8'hBB);
      pokeByte(16'h0000, 8'h01);
      pokeByte(16'h0001, 8'h02);

      $display("[TB] word and sub-word loads");
      expectDone(1'b1, 32'h12345678, 5);
      applyStimulus("lw", 1'b0, 3'b010, 32'h100, 32'd0, 0, -1, 0, -1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("lw_addr%0d", i), trace_a[i], 32'h100 + 32'(i));
      end
      checkOutput("lw_no_write", {28'd0, trace_wr[0], trace_wr[1], trace_wr[2], trace_wr[3]}, 32'd0);

      expectDone(1'b1, 32'hFFFFFF80, 2);
      applyStimulus("lb", 1'b0, 3'b000, 32'h20, 32'd0, 0, -1, 0, -1);
      expectDone(1'b1, 32'h00000080, 2);
      applyStimulus("lbu", 1'b0, 3'b100, 32'h20, 32'd0, 0, -1, 0, -1);
      expectDone(1'b1, 32'hFFFF8001, 3);
      applyStimulus("lh", 1'b0, 3'b001, 32'h40, 32'd0, 0, -1, 0, -1);
      expectDone(1'b1, 32'h00008001, 3);
      applyStimulus("lhu", 1'b0, 3'b101, 32'h40, 32'd0, 0, -1, 0, -1);
      expectDone(1'b1, 32'h9A123456, 5);
      applyStimulus("lw_misaligned", 1'b0, 3'b010, 32'h101, 32'd0, 0, -1, 0, -1);
      expectDone(1'b1, 32'h0201BBAA, 5);
      applyStimulus("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 0, -1, 0, -1);
      checkOutput("lw_wrap_addr2", trace_a[2], 32'h0000_0000);
      checkOutput("lw_wrap_addr3", trace_a[3], 32'h0000_0001);

      $display("[TB] stores");
      expectDone(1'b0, 32'd0, 4);
      applyStimulus("sw", 1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 0, -1, 0, -1);
      checkOutput("sw_wr_trace", {27'd0, trace_wr[0], trace_wr[1], trace_wr[2], trace_wr[3], trace_wr[4]}, 32'b11110);
      checkOutput("sw_nwrites", write_log.size() - wr_start, 32'd4);
      checkWrite("sw_b0", 0, 32'h200, 8'hEF);
      checkWrite("sw_b1", 1, 32'h201, 8'hBE);
      checkWrite("sw_b2", 2, 32'h202, 8'hAD);
      checkWrite("sw_b3", 3, 32'h203, 8'hDE);
      expectDone(1'b1, 32'hDEADBEEF, 5);
      applyStimulus("lw_readback", 1'b0, 3'b010, 32'h200, 32'd0, 0, -1, 0, -1);

      expectDone(1'b0, 32'd0, 2);
      applyStimulus("sh_nonio_full", 1'b1, 3'b001, 32'h210, 32'h0000CAFE, 20, -1, 0, -1);
      checkOutput("sh_nwrites", write_log.size() - wr_start, 32'd2);
      checkWrite("sh_b0", 0, 32'h210, 8'hFE);
      checkWrite("sh_b1", 1, 32'h211, 8'hCA);

      $display("[TB] IO stall");
      expectDone(1'b0, 32'd0, 4);
      applyStimulus("sb_io", 1'b1, 3'b000, 32'h30000, 32'h00000041, 3, -1, 0, -1);
      checkOutput("sb_io_wr_trace", {28'd0, trace_wr[0], trace_wr[1], trace_wr[2], trace_wr[3]}, 32'b0001);
      checkOutput("sb_io_nwrites", write_log.size() - wr_start, 32'd1);
      checkWrite("sb_io_b0", 0, 32'h30000, 8'h41);

      $display("[TB] freeze and flush");
      expectDone(1'b0, 32'd0, 6);
      applyStimulus("sw_freeze", 1'b1, 3'b010, 32'h240, 32'h11223344, 0, 1, 2, -1);
      checkOutput("sw_freeze_gated", {30'd0, trace_wr[2], trace_wr[3]}, 32'd0);
      checkOutput("sw_freeze_nwrites", write_log.size() - wr_start, 32'd4);
      checkWrite("sw_freeze_b0", 0, 32'h240, 8'h44);
      checkWrite("sw_freeze_b1", 1, 32'h241, 8'h33);
      checkWrite("sw_freeze_b2", 2, 32'h242, 8'h22);
      checkWrite("sw_freeze_b3", 3, 32'h243, 8'h11);

      snap = pulse_count;
      expectDone(1'b1, 32'h12345678, 5);
      applyStimulus("lw_flush", 1'b0, 3'b010, 32'h100, 32'd0, 0, -1, 0, 1);
      checkOutput("lw_flush_one_pulse", pulse_count - snap, 32'd1);

      op_type_in    = 7'b0000011;
      op_in         = 3'b010;
      addr_in       = 32'h100;
      lsb_visit_mem = 1'b1;
      rob_clear_up  = 1'b1;
      #1;
      checkOutput("flush_blocks_welcome", {31'd0, cache_welcome_signal}, 32'd0);
      @(posedge clk_in);
      @(negedge clk_in);
      lsb_visit_mem = 1'b0;
      rob_clear_up  = 1'b0;
      #1;
      checkOutput("flush_not_accepted", {31'd0, cache_welcome_signal}, 32'd1);
      snap = pulse_count;
      repeat (8) @(negedge clk_in);
      checkOutput("flush_no_pulse", pulse_count - snap, 32'd0);

      $display("[TB] reset during load");
      lsb_visit_mem = 1'b1;
      @(posedge clk_in);
      @(posedge clk_in);
      @(negedge clk_in);
      #1;
      rst_in = 1'b0;
      #1;
      checkOutput("rst_mid_mem_a", mem_a, 32'd0);
      checkOutput("rst_mid_load_val", load_val_out, 32'd0);
      checkOutput("rst_mid_cache_ready", {31'd0, cache_ready}, 32'd0);
      checkOutput("rst_mid_is_load", {31'd0, is_load}, 32'd0);
      lsb_visit_mem = 1'b0;
      snap = pulse_count;
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      checkOutput("rst_mid_welcome", {31'd0, cache_welcome_signal}, 32'd1);
      repeat (8) @(negedge clk_in);
      checkOutput("rst_mid_no_pulse", pulse_count - snap, 32'd0);
      checkOutput("rst_mid_sb_empty", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
